// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 256;
  localparam int MAX_BURST_DEF = 4;

  // ARB: free arbitration; LOCKn: requester n owns the memory for a burst.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  // One requester's access fields (widths follow the package defaults).
  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen. last=1 means requester 1 won most recently.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot pick; a lone requester always wins.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (r0) and DMA (r1).
// Round-robin arbitration, bounded locked bursts, out-of-range rejection,
// registered read/error responses.
//
// Handshake: rN_req is held with stable fields until rN_gnt is seen high in
// the same cycle; the access is performed in that cycle. Reads and errors
// answer with a single-cycle rN_rvalid pulse one cycle later; writes give no
// response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  output logic              dm_mem_write,
  output logic              dm_mem_read,
  input  logic [DATA_W-1:0] dm_data_out,
  output state_e            dbg_state
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]    req_v, pick, gnt;
  logic          own, own_lock, win, in_range;
  logic [CW-1:0] cnt_inc;
  dmem_req_t     r0_s, r1_s, sel;

  assign req_v = {r1_req, r0_req};
  assign r0_s  = '{we: r0_we, lock: r0_lock,
                   addr: ADDR_W_DEF'(r0_addr), wdata: DATA_W_DEF'(r0_wdata)};
  assign r1_s  = '{we: r1_we, lock: r1_lock,
                   addr: ADDR_W_DEF'(r1_addr), wdata: DATA_W_DEF'(r1_wdata)};

  rr_pick2 u_pick (
    .req   (req_v),
    .last  (last_q),
    .grant (pick)
  );

  // Arbitration FSM: grant selection, burst tracking, round-robin pointer.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt      = 2'b00;
    own      = (state_q == LOCK1);
    own_lock = own ? r1_lock : r0_lock;
    cnt_inc  = cnt_q + CW'(1);
    unique case (state_q)
      ARB: begin
        gnt = pick;
        if (pick != 2'b00) begin
          last_d = pick[1];
          if ((pick[1] ? r1_lock : r0_lock) && (MAX_BURST > 1)) begin
            state_d = pick[1] ? LOCK1 : LOCK0;
            cnt_d   = CW'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (req_v[own]) begin
          gnt[own] = 1'b1;
          last_d   = own;
          cnt_d    = cnt_inc;
          if (!own_lock || (cnt_inc == CW'(MAX_BURST))) begin
            state_d = ARB;
            cnt_d   = '0;
          end
        end else begin
          // Owner released without a request: one dead cycle, back to ARB.
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
    // Nothing is granted (and so nothing is written) while in reset.
    if (rst) gnt = 2'b00;
  end

  // Memory-side mux and response capture for the winning requester.
  always_comb begin
    sel          = gnt[1] ? r1_s : r0_s;
    win          = |gnt;
    in_range     = ADDR_W'(sel.addr) < ADDR_W'(DEPTH);
    dm_address   = '0;
    dm_data_in   = '0;
    dm_mem_write = 1'b0;
    dm_mem_read  = 1'b0;
    rvalid_d     = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    if (win) begin
      dm_address   = ADDR_W'(sel.addr);
      dm_data_in   = DATA_W'(sel.wdata);
      dm_mem_write = sel.we & in_range;
      dm_mem_read  = ~sel.we & in_range;
      if (!sel.we || !in_range) begin
        rvalid_d[gnt[1]] = 1'b1;
        err_d[gnt[1]]    = ~in_range;
        if (gnt[1]) rdata1_d = in_range ? dm_data_out : '0;
        else        rdata0_d = in_range ? dm_data_out : '0;
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_err    = err_q[0];
  assign r1_err    = err_q[1];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single-access vectors, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXB = 4;
  localparam int NV   = 9;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] dm_address, dm_data_in, dm_data_out;
  logic        dm_mem_write, dm_mem_read;
  state_e      dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .dm_address(dm_address), .dm_data_in(dm_data_in),
    .dm_mem_write(dm_mem_write), .dm_mem_read(dm_mem_read),
    .dm_data_out(dm_data_out), .dbg_state(dbg_state)
  );

  // Behavioural 256-word memory with combinational read.
  logic [31:0] mem [256];
  assign dm_data_out = mem[dm_address[7:0]];
  always @(posedge clk) if (dm_mem_write) mem[dm_address[7:0]] <= dm_data_in;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];   // {requester, err, rdata}
  logic [31:0] mem_ref [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic set_r0(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic set_r1(input logic req, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  // Leaves the caller at a falling edge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      mem_ref[i] = 32'hA500_0000 | 32'(i);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        req0, we0;
    logic [31:0] addr0, wd0;
    logic        req1, we1;
    logic [31:0] addr1, wd1;
    logic        g0, g1, rd, wr;
    logic [31:0] a;
    logic        rv0, rv1, err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_din;
    logic [33:0] e;
    logic [1:0]  exp_rv;
    logic        pend [2];
    logic        fwe [2];
    logic        flock [2];
    logic [31:0] faddr [2];
    logic [31:0] fwd [2];
    int          prev_win, w, m_owner, m_cnt, m_last;
    logic        inr, act_rv, act_err;
    logic [31:0] act_rdata;

    rst = 1'b1;
    clear_inputs();
    init_mem();
    mem[5]   = 32'hDEAD_BEEF;
    mem[255] = 32'hCAFE_F00D;

    //          req0  we0   addr0   wd0    req1  we1   addr1          wd1     g0    g1    rd    wr    a              rv0   rv1   err   rdata
    vecs[0] = '{1'b1, 1'b0, 32'd5,  32'd0, 1'b0, 1'b0, 32'd0,         32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd5,         1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, 32'd9,   32'h55,  1'b0, 1'b1, 1'b0, 1'b1, 32'd9,         1'b0, 1'b0, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 32'd9,  32'd0, 1'b1, 1'b0, 32'd3,         32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd9,         1'b1, 1'b0, 1'b0, 32'h55};
    vecs[3] = '{1'b1, 1'b0, 32'd256, 32'd0, 1'b0, 1'b0, 32'd0,        32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 32'd256,       1'b1, 1'b0, 1'b1, 32'd0};
    vecs[4] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b1, 32'd300, 32'h77,  1'b0, 1'b1, 1'b0, 1'b0, 32'd300,       1'b0, 1'b1, 1'b1, 32'd0};
    vecs[5] = '{1'b1, 1'b0, 32'd255, 32'd0, 1'b0, 1'b0, 32'd0,        32'd0,  1'b1, 1'b0, 1'b1, 1'b0, 32'd255,       1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'd0};
    vecs[7] = '{1'b0, 1'b0, 32'd4,  32'd0, 1'b0, 1'b0, 32'd6,         32'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0};
    vecs[8] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1'b0, 32'd0,         32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 1'b0, 32'hA500_0000};

    // ---- reset state ----
    do_reset();
    #1;
    chk("rst r0_gnt", r0_gnt, 0);       chk("rst r1_gnt", r1_gnt, 0);
    chk("rst r0_rvalid", r0_rvalid, 0); chk("rst r1_rvalid", r1_rvalid, 0);
    chk("rst r0_err", r0_err, 0);       chk("rst r1_err", r1_err, 0);
    chk("rst r0_rdata", r0_rdata, 0);   chk("rst r1_rdata", r1_rdata, 0);
    chk("rst dm_address", dm_address, 0);
    chk("rst dm_strobes", {dm_mem_write, dm_mem_read}, 0);
    chk("rst state", dbg_state, ARB);

    // ---- table vectors, each from a fresh reset ----
    for (int i = 0; i < NV; i++) begin
      do_reset();
      set_r0(vecs[i].req0, vecs[i].we0, 1'b0, vecs[i].addr0, vecs[i].wd0);
      set_r1(vecs[i].req1, vecs[i].we1, 1'b0, vecs[i].addr1, vecs[i].wd1);
      #1;
      exp_din = vecs[i].g0 ? vecs[i].wd0 : (vecs[i].g1 ? vecs[i].wd1 : 32'd0);
      chk($sformatf("v%0d r0_gnt", i), r0_gnt, vecs[i].g0);
      chk($sformatf("v%0d r1_gnt", i), r1_gnt, vecs[i].g1);
      chk($sformatf("v%0d dm_mem_read", i), dm_mem_read, vecs[i].rd);
      chk($sformatf("v%0d dm_mem_write", i), dm_mem_write, vecs[i].wr);
      chk($sformatf("v%0d dm_address", i), dm_address, vecs[i].a);
      chk($sformatf("v%0d dm_data_in", i), dm_data_in, exp_din);
      @(negedge clk);
      clear_inputs();
      chk($sformatf("v%0d r0_rvalid", i), r0_rvalid, vecs[i].rv0);
      chk($sformatf("v%0d r1_rvalid", i), r1_rvalid, vecs[i].rv1);
      if (vecs[i].rv0) begin
        chk($sformatf("v%0d r0_err", i), r0_err, vecs[i].err);
        chk($sformatf("v%0d r0_rdata", i), r0_rdata, vecs[i].rdata);
      end
      if (vecs[i].rv1) begin
        chk($sformatf("v%0d r1_err", i), r1_err, vecs[i].err);
        chk($sformatf("v%0d r1_rdata", i), r1_rdata, vecs[i].rdata);
      end
    end

    // ---- alternation with write-then-read through the other port ----
    do_reset();
    set_r0(1, 0, 0, 32'd1, 32'd0);
    set_r1(1, 1, 0, 32'd7, 32'h11);
    #1; chk("alt c0 gnt", {r1_gnt, r0_gnt}, 2'b01);
    @(negedge clk);
    set_r0(1, 0, 0, 32'd7, 32'd0);
    #1; chk("alt c1 gnt", {r1_gnt, r0_gnt}, 2'b10);
    chk("alt c1 write", {dm_mem_write, dm_address}, {1'b1, 32'd7});
    @(negedge clk);
    set_r1(1, 1, 0, 32'd8, 32'h22);
    #1; chk("alt c2 gnt", {r1_gnt, r0_gnt}, 2'b01);
    chk("alt c2 read", {dm_mem_read, dm_address}, {1'b1, 32'd7});
    @(negedge clk);
    set_r0(1, 0, 0, 32'd2, 32'd0);
    #1; chk("alt c3 gnt", {r1_gnt, r0_gnt}, 2'b10);
    chk("alt c3 r0_rvalid", r0_rvalid, 1);
    chk("alt c3 r0_rdata", r0_rdata, 32'h11);
    @(negedge clk);
    clear_inputs();

    // ---- r1 locked burst of MAXB grants, r0 waiting ----
    do_reset();
    set_r1(1, 0, 1, 32'd3, 32'd0);
    #1; chk("lock c0 gnt", {r1_gnt, r0_gnt}, 2'b10);
    for (int k = 1; k < MAXB; k++) begin
      @(negedge clk);
      set_r0(1, 0, 0, 32'd4, 32'd0);
      set_r1(1, 0, 1, 32'(3 + k), 32'd0);
      #1;
      chk($sformatf("lock c%0d gnt", k), {r1_gnt, r0_gnt}, 2'b10);
      chk($sformatf("lock c%0d state", k), dbg_state, LOCK1);
    end
    @(negedge clk);
    set_r1(1, 0, 1, 32'd10, 32'd0);
    #1; chk("lock end r0 wins", {r1_gnt, r0_gnt}, 2'b01);
    chk("lock end state", dbg_state, ARB);
    @(negedge clk);
    clear_inputs();

    // ---- locked owner drops req: one dead cycle ----
    do_reset();
    set_r0(1, 0, 1, 32'd1, 32'd0);
    #1; chk("dead c0 gnt", {r1_gnt, r0_gnt}, 2'b01);
    @(negedge clk);
    set_r0(0, 0, 0, 32'd0, 32'd0);
    set_r1(1, 0, 0, 32'd2, 32'd0);
    #1; chk("dead c1 gnt", {r1_gnt, r0_gnt}, 2'b00);
    @(negedge clk);
    #1; chk("dead c2 gnt", {r1_gnt, r0_gnt}, 2'b10);
    @(negedge clk);
    clear_inputs();

    // ---- reset in the middle of an r0 locked write burst ----
    do_reset();
    set_r0(1, 1, 1, 32'd20, 32'h1111);
    #1; chk("rstb c0 write", {r0_gnt, dm_mem_write}, 2'b11);
    @(negedge clk);
    set_r0(1, 1, 1, 32'd21, 32'h2222);
    set_r1(1, 0, 0, 32'd6, 32'd0);
    rst = 1'b1;
    #1; chk("rstb c1 write blocked", {r0_gnt, dm_mem_write}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    set_r0(0, 0, 0, 32'd0, 32'd0);
    #1; chk("rstb state", dbg_state, ARB);
    chk("rstb r1 first", {r1_gnt, r0_gnt}, 2'b10);
    @(negedge clk);
    clear_inputs();
    chk("rstb r1 rdata", {r1_rvalid, r1_rdata}, {1'b1, 32'hA500_0006});
    chk("rstb mem20", mem[20], 32'h1111);
    chk("rstb mem21", mem[21], 32'hA500_0015);

    // ---- randomized traffic against the reference model ----
    init_mem();
    do_reset();
    exp_q.delete();
    exp_rv   = 2'b00;
    prev_win = -1;
    m_owner  = -1;
    m_cnt    = 0;
    m_last   = 1;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; fwe[n] = 0; flock[n] = 0; faddr[n] = '0; fwd[n] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // responses produced by last cycle's grant
      for (int n = 0; n < 2; n++) begin
        act_rv    = n ? r1_rvalid : r0_rvalid;
        act_err   = n ? r1_err : r0_err;
        act_rdata = n ? r1_rdata : r0_rdata;
        chk($sformatf("rnd%0d r%0d_rvalid", cyc, n), act_rv, exp_rv[n]);
        if (exp_rv[n] && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("rnd%0d r%0d_err", cyc, n), act_err, e[32]);
          chk($sformatf("rnd%0d r%0d_rdata", cyc, n), act_rdata, e[31:0]);
        end
      end
      // new requests where the port is idle or was just served
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] || prev_win == n) begin
          pend[n]  = ($urandom_range(0, 3) != 0);
          fwe[n]   = 1'($urandom_range(0, 1));
          flock[n] = ($urandom_range(0, 2) == 0);
          fwd[n]   = $urandom;
          if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
              0:       faddr[n] = 32'd256;
              1:       faddr[n] = 32'hFFFF_FFFF;
              default: faddr[n] = $urandom_range(257, 100000);
            endcase
          end else begin
            faddr[n] = $urandom_range(0, 15);
          end
        end
      end
      set_r0(pend[0], fwe[0], flock[0], faddr[0], fwd[0]);
      set_r1(pend[1], fwe[1], flock[1], faddr[1], fwd[1]);
      #1;
      // who should win this cycle
      w = -1;
      if (m_owner >= 0) begin
        if (pend[m_owner]) w = m_owner;
        else m_owner = -1;
      end else if (pend[0] && pend[1]) begin
        w = 1 - m_last;
      end else if (pend[0]) begin
        w = 0;
      end else if (pend[1]) begin
        w = 1;
      end
      chk($sformatf("rnd%0d gnt", cyc), {r1_gnt, r0_gnt}, {w == 1, w == 0});
      exp_rv = 2'b00;
      if (w >= 0) begin
        inr = (faddr[w] < 32'd256);
        chk($sformatf("rnd%0d dm_address", cyc), dm_address, faddr[w]);
        chk($sformatf("rnd%0d dm_data_in", cyc), dm_data_in, fwd[w]);
        chk($sformatf("rnd%0d dm_strobes", cyc), {dm_mem_write, dm_mem_read},
            {fwe[w] && inr, !fwe[w] && inr});
        if (!inr) begin
          exp_rv[w] = 1'b1;
          exp_q.push_back({w[0], 1'b1, 32'd0});
        end else if (!fwe[w]) begin
          exp_rv[w] = 1'b1;
          exp_q.push_back({w[0], 1'b0, mem_ref[faddr[w][7:0]]});
        end else begin
          mem_ref[faddr[w][7:0]] = fwd[w];
        end
        m_last = w;
        if (m_owner < 0) begin
          if (flock[w] && MAXB > 1) begin
            m_owner = w;
            m_cnt   = 1;
          end
        end else begin
          m_cnt++;
          if (!flock[w] || m_cnt == MAXB) m_owner = -1;
        end
      end else begin
        chk($sformatf("rnd%0d idle dm", cyc),
            {dm_mem_write, dm_mem_read, dm_address, dm_data_in}, 0);
      end
      prev_win = w;
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("final mem%0d", i), mem[i], mem_ref[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
